// File: rtl/fighter_anim_ctrl.sv
// Per-fighter animation sequencer: maps controls and combat events to a registered anim state/frame.
// Optional macro COMBO_CHAIN_EN: btn_atk1 during the last ATK1 frame chains straight into ATK2.
module fighter_anim_ctrl #(
    parameter int unsigned ATK1_FRAMES    = 4,
    parameter int unsigned ATK2_FRAMES    = 6,
    parameter int unsigned FRAME_HOLD     = 4,
    parameter int unsigned ATK1_ACT_FRAME = 2,
    parameter int unsigned ATK2_ACT_FRAME = 3,
    parameter int unsigned JUMP_TICKS     = 30,
    parameter int unsigned HITSTUN_TICKS  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_atk1,
    input  logic       btn_atk2,
    input  logic       hit_in,
    input  logic       ko_in,
    output logic [3:0] anim_state,
    output logic [5:0] anim_frame,
    output logic       attack_active,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_WALK = 4'd1,
        S_JUMP = 4'd2,
        S_ATK1 = 4'd3,
        S_ATK2 = 4'd4,
        S_HIT  = 4'd5,
        S_LOSE = 4'd6
    } state_t;

    localparam logic [5:0] LAST1     = 6'(ATK1_FRAMES - 1);
    localparam logic [5:0] LAST2     = 6'(ATK2_FRAMES - 1);
    localparam logic [5:0] ACT1      = 6'(ATK1_ACT_FRAME);
    localparam logic [5:0] ACT2      = 6'(ATK2_ACT_FRAME);
    localparam logic [7:0] HOLD_LAST = 8'(FRAME_HOLD - 1);
    localparam logic [7:0] JUMP_LAST = 8'(JUMP_TICKS - 1);
    localparam logic [7:0] HIT_LAST  = 8'(HITSTUN_TICKS - 1);

    state_t     state, state_n;
    logic [5:0] frame, frame_n;
    logic [7:0] hold, hold_n;
    logic [7:0] ticks, ticks_n;
    logic       enter;
    logic       act_n, busy_n;
`ifdef COMBO_CHAIN_EN
    logic       combo, combo_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            frame         <= '0;
            hold          <= '0;
            ticks         <= '0;
            attack_active <= 1'b0;
            busy          <= 1'b0;
`ifdef COMBO_CHAIN_EN
            combo         <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            frame         <= frame_n;
            hold          <= hold_n;
            ticks         <= ticks_n;
            attack_active <= act_n;
            busy          <= busy_n;
`ifdef COMBO_CHAIN_EN
            combo         <= combo_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        frame_n = frame;
        hold_n  = hold;
        ticks_n = ticks;
        enter   = 1'b0;
`ifdef COMBO_CHAIN_EN
        combo_n = combo;
`endif
        if (state == S_LOSE) begin
            frame_n = '0;
        end else if (ko_in) begin
            state_n = S_LOSE;
            enter   = 1'b1;
        end else if (hit_in) begin
            // A hit also discards any coincident frame_tick.
            state_n = S_HIT;
            enter   = 1'b1;
        end else if (frame_tick) begin
            case (state)
                S_IDLE, S_WALK: begin
                    enter = 1'b1;
                    if (btn_atk1)                   state_n = S_ATK1;
                    else if (btn_atk2)              state_n = S_ATK2;
                    else if (btn_jump)              state_n = S_JUMP;
                    else if (btn_left ^ btn_right)  state_n = S_WALK;
                    else                            state_n = S_IDLE;
                end
                S_ATK1: begin
`ifdef COMBO_CHAIN_EN
                    if (frame == LAST1 && btn_atk1) combo_n = 1'b1;
`endif
                    if (hold == HOLD_LAST) begin
                        hold_n = '0;
                        if (frame == LAST1) begin
                            enter   = 1'b1;
                            state_n = S_IDLE;
`ifdef COMBO_CHAIN_EN
                            if (combo || btn_atk1) state_n = S_ATK2;
`endif
                        end else begin
                            frame_n = frame + 6'd1;
                        end
                    end else begin
                        hold_n = hold + 8'd1;
                    end
                end
                S_ATK2: begin
                    if (hold == HOLD_LAST) begin
                        hold_n = '0;
                        if (frame == LAST2) begin
                            enter   = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            frame_n = frame + 6'd1;
                        end
                    end else begin
                        hold_n = hold + 8'd1;
                    end
                end
                S_JUMP: begin
                    if (ticks == JUMP_LAST) begin
                        enter   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ticks_n = ticks + 8'd1;
                    end
                end
                S_HIT: begin
                    if (ticks == HIT_LAST) begin
                        enter   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ticks_n = ticks + 8'd1;
                    end
                end
                default: ;
            endcase
        end
        if (enter) begin
            frame_n = '0;
            hold_n  = '0;
            ticks_n = '0;
`ifdef COMBO_CHAIN_EN
            combo_n = 1'b0;
`endif
        end
        act_n  = (state_n == S_ATK1 && frame_n == ACT1) ||
                 (state_n == S_ATK2 && frame_n == ACT2);
        busy_n = state_n inside {S_JUMP, S_ATK1, S_ATK2, S_HIT, S_LOSE};
    end

    assign anim_state = state;
    assign anim_frame = frame;

endmodule

// File: doc/fighter_anim_ctrl.md
Name: fighter_anim_ctrl

Overview:
Per-fighter animation sequencer that directly feeds the sprite mapper's anim_state/anim_frame inputs. Converts player controls and combat events into a registered animation state and in-state frame index, timed by the once-per-video-frame frame_tick. Also produces the hitbox-active strobe and busy flag used by the collision/combat logic. One instance per fighter.

Parameters:
ATK1_FRAMES, 4, number of anim frames in attack 1 (1..63)
ATK2_FRAMES, 6, number of anim frames in attack 2 (1..63)
FRAME_HOLD, 4, frame_ticks each attack anim frame is held (1..255)
ATK1_ACT_FRAME, 2, attack-1 frame index on which the hitbox is live
ATK2_ACT_FRAME, 3, attack-2 frame index on which the hitbox is live
JUMP_TICKS, 30, frame_ticks spent in JUMP (1..255)
HITSTUN_TICKS, 20, frame_ticks spent in HIT (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
frame_tick  in  1  one-cycle pulse per video frame
btn_left  in  1  move-left held
btn_right  in  1  move-right held
btn_jump  in  1  jump held
btn_atk1  in  1  attack-1 held
btn_atk2  in  1  attack-2 held
hit_in  in  1  one-cycle pulse: fighter was struck
ko_in  in  1  level: fighter health is zero
anim_state  out  4  0 idle, 1 walk, 2 jump, 3 atk1, 4 atk2, 5 hit, 6 lose
anim_frame  out  6  frame index within the current state
attack_active  out  1  hitbox live
busy  out  1  high in JUMP, ATK1, ATK2, HIT, LOSE

Behaviour:
- One clock, clk; rst is synchronous and active-high. On rst: anim_state=0, anim_frame=0, attack_active=0, busy=0, all internal counters=0. rst overrides all other inputs.
- All outputs registered; an event sampled on edge N is visible after edge N.
- Every state entry clears anim_frame, the hold counter and the tick counter.
- Priority, evaluated every cycle (not gated by frame_tick): ko_in -> LOSE; else hit_in -> HIT (from any state except LOSE; a hit during HIT restarts HITSTUN_TICKS).
- LOSE is absorbing until rst; anim_frame held at 0.
- Remaining transitions only on cycles with frame_tick=1:
  IDLE/WALK: atk1 -> ATK1; else atk2 -> ATK2; else jump -> JUMP; else left XOR right -> WALK; else IDLE. Both directions held means IDLE.
  ATK1/ATK2: hold counter increments. When it reaches FRAME_HOLD-1, it wraps to 0 and anim_frame increments. At the wrap of the last frame (ATKn_FRAMES-1), the block goes to IDLE. Total duration is exactly ATKn_FRAMES*FRAME_HOLD ticks after entry. Buttons are ignored.
  JUMP/HIT: tick counter increments. On reaching JUMP_TICKS / HITSTUN_TICKS, the block goes to IDLE. anim_frame stays 0.
- The entry tick is not counted in any duration.
- attack_active = (state==ATK1 && anim_frame==ATK1_ACT_FRAME) || (state==ATK2 && anim_frame==ATK2_ACT_FRAME). It is decoded from registered state, so it is aligned with the outputs.
- anim_frame never exceeds ATKn_FRAMES-1. No wrap-around is possible.
- frame_tick and hit_in on the same cycle: the hit wins and the tick is discarded.

Optional Feature:
COMBO_CHAIN_EN. When defined, btn_atk1 sampled on any frame_tick during the final anim frame of ATK1 sets a combo latch. At ATK1 completion the block enters ATK2 (frame 0) instead of IDLE, and the latch clears. HIT, LOSE or rst clear the latch. When undefined, there is no latch and ATK1 always returns to IDLE.

Test Plan:
- rst held 2 cycles with all buttons high -> anim_state=0, anim_frame=0, attack_active=0, busy=0.
- btn_right held, 1 tick -> state 1; release, next tick -> state 0; left+right held -> state 0.
- btn_atk1 pulse at a tick (defaults) -> state 3; anim_frame steps 0,1,2,3 every 4 ticks; attack_active high only during frame 2 (4 ticks); state 0 on the 16th tick after entry.
- Jump entry, then hit_in at tick 10 -> state 5 next cycle; second hit_in at tick 15 of HIT -> returns to IDLE 20 ticks after the second hit.
- During ATK2 frame 4, ko_in=1 -> state 6 next cycle; then hit_in and buttons -> stays 6; rst -> state 0.
- COMBO_CHAIN_EN defined: btn_atk1 on ATK1 frame 3 -> state 4 frame 0 immediately after ATK1's last tick. Undefined: same stimulus -> state 0.
